// File: rtl/mux_sel_sequencer.sv
// Ordered two-key select sequencer for the 2:1 source mux: sel_b1 leads sel_b2 on arm and trails it on disarm.
// Optional post-disarm lockout on source a: define MUX_SEL_SEQUENCER_HOLDOFF_EN.
module mux_sel_sequencer #(
    parameter int unsigned ARM_CYC  = 4,
    parameter int unsigned DIS_CYC  = 4,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_b,
    input  logic             force_a,
    output logic             sel_b1,
    output logic             sel_b2,
    output logic             on_b,
    output logic             busy,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int unsigned MAX_AD  = (ARM_CYC > DIS_CYC) ? ARM_CYC : DIS_CYC;
    localparam int unsigned MAX_CYC = (MAX_AD > HOLD_CYC) ? MAX_AD : HOLD_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] ARM_LD = CW'(ARM_CYC - 1);
    localparam logic [CW-1:0] DIS_LD = CW'(DIS_CYC - 1);

`ifdef MUX_SEL_SEQUENCER_HOLDOFF_EN
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    typedef enum logic [2:0] {IDLE_A, ARM1, ON_B, DISARM, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE_A, ARM1, ON_B, DISARM} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          req;

    assign req = req_b & ~force_a;

    // Outputs are registered alongside the state they decode, so each one
    // changes on the same edge as the transition that defines it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_A;
            cnt        <= '0;
            sel_b1     <= 1'b0;
            sel_b2     <= 1'b0;
            on_b       <= 1'b0;
            busy       <= 1'b0;
            switch_cnt <= '0;
        end else begin
            case (state)
                IDLE_A: begin
                    if (req) begin
                        state  <= ARM1;
                        cnt    <= ARM_LD;
                        sel_b1 <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ARM1: begin
                    if (!req) begin
                        state  <= IDLE_A;
                        sel_b1 <= 1'b0;
                        busy   <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= ON_B;
                        sel_b2 <= 1'b1;
                        on_b   <= 1'b1;
                        busy   <= 1'b0;
                        if (switch_cnt != '1) begin
                            switch_cnt <= switch_cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ON_B: begin
                    if (!req) begin
                        state  <= DISARM;
                        cnt    <= DIS_LD;
                        sel_b2 <= 1'b0;
                        on_b   <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                DISARM: begin
                    if (cnt == '0) begin
                        sel_b1 <= 1'b0;
`ifdef MUX_SEL_SEQUENCER_HOLDOFF_EN
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
`else
                        state  <= IDLE_A;
                        busy   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef MUX_SEL_SEQUENCER_HOLDOFF_EN
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE_A;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                default: begin
                    state  <= IDLE_A;
                    cnt    <= '0;
                    sel_b1 <= 1'b0;
                    sel_b2 <= 1'b0;
                    on_b   <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: key-level timeline model checked every cycle, plus literal timing points.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_mux_sel_sequencer;

    localparam int unsigned ARM_CYC  = 4;
    localparam int unsigned DIS_CYC  = 4;
    localparam int unsigned HOLD_CYC = 8;
`ifdef MUX_SEL_SEQUENCER_HOLDOFF_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       req_b   = 1'b0;
    logic       force_a = 1'b0;
    logic       sel_b1, sel_b2, on_b, busy;
    logic [7:0] switch_cnt;
    logic       s_b1, s_b2, s_on, s_busy;
    logic [1:0] s_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mux_sel_sequencer #(
        .ARM_CYC (ARM_CYC),
        .DIS_CYC (DIS_CYC),
        .HOLD_CYC(HOLD_CYC),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_b     (req_b),
        .force_a   (force_a),
        .sel_b1    (sel_b1),
        .sel_b2    (sel_b2),
        .on_b      (on_b),
        .busy      (busy),
        .switch_cnt(switch_cnt)
    );

    mux_sel_sequencer #(
        .ARM_CYC (ARM_CYC),
        .DIS_CYC (DIS_CYC),
        .HOLD_CYC(HOLD_CYC),
        .CNT_W   (2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_b     (req_b),
        .force_a   (force_a),
        .sel_b1    (s_b1),
        .sel_b2    (s_b2),
        .on_b      (s_on),
        .busy      (s_busy),
        .switch_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_to(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Model: key levels, arming direction and cycles elapsed since the last key change.
    bit          m_b1, m_b2, m_up, m_hold, m_req, m_chg;
    int unsigned m_age, m_el, m_sw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b1 = 0; m_b2 = 0; m_up = 0; m_hold = 0; m_age = 0; m_sw = 0;
        end else begin
            m_req = req_b && !force_a;
            m_el  = m_age + 1;
            m_chg = 1'b1;
            if (!m_b1) begin
                if (m_req && !(m_hold && m_el <= HOLD_CYC)) begin
                    m_b1 = 1; m_up = 1; m_hold = 0;
                end else m_chg = 0;
            end else if (m_b2) begin
                if (!m_req) begin
                    m_b2 = 0; m_up = 0;
                end else m_chg = 0;
            end else if (m_up) begin
                if (!m_req) m_b1 = 0;
                else if (m_el == ARM_CYC) begin
                    m_b2 = 1; m_sw++;
                end else m_chg = 0;
            end else begin
                if (m_el == DIS_CYC) begin
                    m_b1 = 0; m_hold = HOLD_ON;
                end else m_chg = 0;
            end
            m_age = m_chg ? 0 : m_el;
        end
    end

    bit p_ok = 0;
    bit p_b1, p_b2;

    always @(negedge clk) begin
        bit e_busy;
        e_busy = (m_b1 && !m_b2) || (m_hold && !m_b1 && m_age < HOLD_CYC);
        check("sel_b1",     sel_b1,     m_b1);
        check("sel_b2",     sel_b2,     m_b2);
        check("on_b",       on_b,       m_b1 && m_b2);
        check("busy",       busy,       e_busy);
        check("switch_cnt", switch_cnt, sat_to(m_sw, 255));
        check("sat_sel_b1", s_b1,       m_b1);
        check("sat_sel_b2", s_b2,       m_b2);
        check("sat_cnt",    s_cnt,      sat_to(m_sw, 3));
        if (rst_n && p_ok) begin
            check("inv_b2_needs_b1", !sel_b2 || sel_b1, 1);
            check("inv_b1_steady",   !(p_b2 || sel_b2) || (sel_b1 == p_b1), 1);
            check("inv_one_key",     !((sel_b1 != p_b1) && (sel_b2 != p_b2)), 1);
        end
        p_ok = rst_n;
        p_b1 = sel_b1;
        p_b2 = sel_b2;
    end

    task automatic after_edges(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_b1"},   sel_b1,     0);
        check({tag, "_b2"},   sel_b2,     0);
        check({tag, "_on"},   on_b,       0);
        check({tag, "_busy"}, busy,       0);
        check({tag, "_cnt"},  switch_cnt, 0);
        check({tag, "_scnt"}, s_cnt,      0);
    endtask

    task automatic full_switch(input logic [7:0] e_main, input logic [1:0] e_sat);
        after_edges(10);
        req_b = 1;
        after_edges(5);
        check("fs_on_b", on_b, 1);
        check("fs_cnt",  switch_cnt, e_main);
        check("fs_scnt", s_cnt, e_sat);
        req_b = 0;
        after_edges(5);
        check("fs_b1_off", sel_b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        // Arm: sel_b1 one edge after the request, sel_b2 ARM_CYC edges later.
        after_edges(3);
        req_b = 1;
        after_edges(1);
        check("arm_b1", sel_b1, 1); check("arm_b2", sel_b2, 0); check("arm_busy", busy, 1);
        after_edges(3);
        check("arm_b2_late", sel_b2, 0);
        after_edges(1);
        check("on_b2", sel_b2, 1); check("on_on", on_b, 1); check("on_busy", busy, 0);
        check("on_cnt", switch_cnt, 1); check("on_scnt", s_cnt, 1);

        // Disarm: sel_b2 drops first, sel_b1 DIS_CYC edges later.
        after_edges(3);
        req_b = 0;
        after_edges(1);
        check("dis_b2", sel_b2, 0); check("dis_b1", sel_b1, 1); check("dis_busy", busy, 1);
        after_edges(3);
        check("dis_b1_late", sel_b1, 1); check("dis_busy_late", busy, 1);
        after_edges(1);
        check("dis_b1_off", sel_b1, 0); check("dis_busy_off", busy, 0);

        // Abort after two request cycles.
        after_edges(10);
        req_b = 1;
        after_edges(1);
        check("ab_b1_1", sel_b1, 1);
        after_edges(1);
        check("ab_b1_2", sel_b1, 1); check("ab_b2", sel_b2, 0);
        req_b = 0;
        after_edges(1);
        check("ab_b1_off", sel_b1, 0); check("ab_busy", busy, 0); check("ab_cnt", switch_cnt, 1);

        // force_a from ON_B: ordered disarm, no re-arm while held.
        after_edges(10);
        req_b = 1;
        after_edges(5);
        check("fa_on", on_b, 1); check("fa_cnt", switch_cnt, 2); check("fa_scnt", s_cnt, 2);
        after_edges(2);
        force_a = 1;
        after_edges(1);
        check("fa_b2", sel_b2, 0); check("fa_b1", sel_b1, 1);
        after_edges(4);
        check("fa_b1_off", sel_b1, 0);
        after_edges(8);
        check("fa_held_b1", sel_b1, 0); check("fa_held_busy", busy, 0);
        force_a = 0;
        after_edges(1);
        check("fa_rearm", sel_b1, 1);
        after_edges(4);
        check("fa_on2", on_b, 1); check("fa_cnt2", switch_cnt, 3); check("fa_scnt2", s_cnt, 3);
        req_b = 0;
        after_edges(5);
        check("fa_b1_off2", sel_b1, 0);

        full_switch(8'd4, 2'd3);
        full_switch(8'd5, 2'd3);

        // Asynchronous reset in ARM1, then in ON_B.
        after_edges(10);
        req_b = 1;
        after_edges(1);
        check("ra_b1", sel_b1, 1);
        #2 rst_n = 0;
        #1 check_zero("ra");
        after_edges(1);
        #2 rst_n = 1;
        after_edges(1);
        check("ra_rearm", sel_b1, 1);
        after_edges(4);
        check("ro_on", on_b, 1); check("ro_cnt", switch_cnt, 1);
        #2 rst_n = 0;
        #1 check_zero("ro");
        req_b = 0;
        after_edges(1);
        #2 rst_n = 1;

`ifndef MUX_SEL_SEQUENCER_HOLDOFF_EN
        // Request re-asserted during DISARM is served only from IDLE_A.
        after_edges(3);
        req_b = 1;
        after_edges(5);
        check("rr_on", on_b, 1);
        req_b = 0;
        after_edges(1);
        check("rr_b2", sel_b2, 0);
        req_b = 1;
        after_edges(3);
        check("rr_b1_hold", sel_b1, 1); check("rr_b2_low", sel_b2, 0);
        after_edges(1);
        check("rr_idle", sel_b1, 0);
        after_edges(1);
        check("rr_rearm", sel_b1, 1);
        req_b = 0;
`endif
        after_edges(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
